// File: rtl/register_tree_pq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : register_tree_pq_if                                          |
// | Description : Push/pop request and head-status bundle for register_tree_pq.|
// |               The o_err member exists only with REGISTER_TREE_PQ_ERR_EN.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface register_tree_pq_if #(
  parameter int QUEUE_SIZE    = 128,
  parameter int KEY_WIDTH     = 16,
  parameter int PAYLOAD_WIDTH = 8
);
  localparam int c_size_w = $clog2(QUEUE_SIZE) + 1;

  logic                     i_push;
  logic                     i_pop;
  logic [KEY_WIDTH-1:0]     i_key;
  logic [PAYLOAD_WIDTH-1:0] i_payload;
  logic                     o_full;
  logic                     o_empty;
  logic                     o_valid;
  logic [KEY_WIDTH-1:0]     o_key;
  logic [PAYLOAD_WIDTH-1:0] o_payload;
  logic [c_size_w-1:0]      o_size;
`ifdef REGISTER_TREE_PQ_ERR_EN
  logic                     o_err;
`endif

  modport master (
`ifdef REGISTER_TREE_PQ_ERR_EN
    input  o_err,
`endif
    output i_push, i_pop, i_key, i_payload,
    input  o_full, o_empty, o_valid, o_key, o_payload, o_size
  );

  modport slave (
`ifdef REGISTER_TREE_PQ_ERR_EN
    output o_err,
`endif
    input  i_push, i_pop, i_key, i_payload,
    output o_full, o_empty, o_valid, o_key, o_payload, o_size
  );
endinterface
`default_nettype wire

// File: rtl/register_tree_pq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : register_tree_pq                                             |
// | Description : Register-tree priority queue with alternating-phase          |
// |               compare-swap cells and a head settle tracker.                |
// |               Optional macro REGISTER_TREE_PQ_ERR_EN adds sticky o_err.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module register_tree_pq #(
  parameter int QUEUE_SIZE    = 128,
  parameter int KEY_WIDTH     = 16,
  parameter int PAYLOAD_WIDTH = 8,
  parameter int MAX_FIRST     = 1
) (
  input wire                CLK,
  input wire                RSTn,
  register_tree_pq_if.slave pq
);
  localparam int c_depth      = $clog2(QUEUE_SIZE);
  localparam int c_nodes      = 2 * QUEUE_SIZE - 1;
  localparam int c_first_leaf = QUEUE_SIZE - 1;
  localparam int c_size_w     = c_depth + 1;
  localparam int c_cnt_w      = $clog2(2 * c_depth + 1);
  localparam int c_idx_w      = $clog2(c_nodes);
  localparam logic [c_cnt_w-1:0]  c_settle_load = c_cnt_w'(2 * c_depth);
  localparam logic [c_size_w-1:0] c_size_full   = c_size_w'(QUEUE_SIZE);

  typedef struct packed {
    logic                     valid;
    logic [KEY_WIDTH-1:0]     key;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } entry_t;

  typedef enum logic [0:0] {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_t;

  typedef enum logic [1:0] {
    MD_REPLACE = 2'd0,
    MD_PUSH    = 2'd1,
    MD_POP     = 2'd2,
    MD_SORT    = 2'd3
  } mode_t;

  entry_t              r_node     [c_nodes];
  entry_t              w_sort     [c_nodes];
  entry_t              w_node_nxt [c_nodes];
  entry_t              w_new_entry;
  entry_t              w_par;
  entry_t              w_lft;
  entry_t              w_rgt;
  entry_t              w_best;
  logic [1:0]          w_sel;
  phase_t              r_phase;
  phase_t              w_phase_nxt;
  mode_t               w_mode;
  logic [c_size_w-1:0] r_size;
  logic [c_size_w-1:0] w_size_nxt;
  logic [c_cnt_w-1:0]  r_settle;
  logic [c_cnt_w-1:0]  w_settle_nxt;
  logic [c_idx_w-1:0]  w_free_idx;
  logic                w_full;
  logic                w_empty;
  logic                w_valid;
  logic                w_push_ok;
  logic                w_pop_ok;
  logic                w_replace;

  // An invalid entry never wins; equal keys never displace, which keeps ties stable.
  function automatic logic beats(input entry_t a, input entry_t b);
    logic better_key;
    better_key = (MAX_FIRST != 0) ? (a.key > b.key) : (a.key < b.key);
    return a.valid && (!b.valid || better_key);
  endfunction

  assign w_full    = (r_size == c_size_full);
  assign w_empty   = (r_size == '0);
  assign w_valid   = !w_empty && (r_settle == '0);
  assign w_push_ok = pq.i_push && !w_full;
  assign w_pop_ok  = pq.i_pop && w_valid;
  assign w_replace = pq.i_push && pq.i_pop && w_valid;

  always_comb begin
    w_mode = MD_SORT;
    if (w_replace) begin
      w_mode = MD_REPLACE;
    end else if (w_push_ok) begin
      w_mode = MD_PUSH;
    end else if (w_pop_ok) begin
      w_mode = MD_POP;
    end
  end

  // Cells on one level parity never share a node, so all of them can act at once.
  always_comb begin
    w_sort = r_node;
    w_par  = '0;
    w_lft  = '0;
    w_rgt  = '0;
    w_best = '0;
    w_sel  = 2'd0;
    for (int lvl = 0; lvl < c_depth; lvl++) begin
      for (int k = 0; k < (1 << lvl); k++) begin
        if (((lvl % 2) == 0) == (r_phase == PH_EVEN)) begin
          w_par  = r_node[(1 << lvl) - 1 + k];
          w_lft  = r_node[2 * ((1 << lvl) - 1 + k) + 1];
          w_rgt  = r_node[2 * ((1 << lvl) - 1 + k) + 2];
          w_best = w_par;
          w_sel  = 2'd0;
          if (beats(w_lft, w_best)) begin
            w_best = w_lft;
            w_sel  = 2'd1;
          end
          if (beats(w_rgt, w_best)) begin
            w_best = w_rgt;
            w_sel  = 2'd2;
          end
          w_sort[(1 << lvl) - 1 + k] = w_best;
          if (w_sel == 2'd1) begin
            w_sort[2 * ((1 << lvl) - 1 + k) + 1] = w_par;
          end
          if (w_sel == 2'd2) begin
            w_sort[2 * ((1 << lvl) - 1 + k) + 2] = w_par;
          end
        end
      end
    end
  end

  always_comb begin
    w_free_idx = c_idx_w'(c_first_leaf);
    for (int j = c_nodes - 1; j >= c_first_leaf; j--) begin
      if (!r_node[j].valid) begin
        w_free_idx = c_idx_w'(j);
      end
    end
  end

  always_comb begin
    w_node_nxt  = r_node;
    w_new_entry = '{valid: 1'b1, key: pq.i_key, payload: pq.i_payload};
    case (w_mode)
      MD_REPLACE: w_node_nxt[0] = w_new_entry;
      MD_PUSH:    w_node_nxt[w_free_idx] = w_new_entry;
      MD_POP:     w_node_nxt[0].valid = 1'b0;
      default:    w_node_nxt = w_sort;
    endcase
  end

  always_comb begin
    w_phase_nxt  = r_phase;
    w_size_nxt   = r_size;
    w_settle_nxt = r_settle;
    case (w_mode)
      MD_REPLACE: begin
        w_settle_nxt = c_settle_load;
      end
      MD_PUSH: begin
        w_size_nxt   = r_size + c_size_w'(1);
        w_settle_nxt = c_settle_load;
      end
      MD_POP: begin
        w_size_nxt   = r_size - c_size_w'(1);
        w_settle_nxt = c_settle_load;
      end
      default: begin
        w_phase_nxt = (r_phase == PH_EVEN) ? PH_ODD : PH_EVEN;
        if (r_settle != '0) begin
          w_settle_nxt = r_settle - c_cnt_w'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int n = 0; n < c_nodes; n++) begin
        r_node[n] <= '0;
      end
      r_phase  <= PH_EVEN;
      r_size   <= '0;
      r_settle <= '0;
    end else begin
      r_node   <= w_node_nxt;
      r_phase  <= w_phase_nxt;
      r_size   <= w_size_nxt;
      r_settle <= w_settle_nxt;
    end
  end

  assign pq.o_full    = w_full;
  assign pq.o_empty   = w_empty;
  assign pq.o_valid   = w_valid;
  assign pq.o_size    = r_size;
  assign pq.o_key     = r_node[0].valid ? r_node[0].key : '0;
  assign pq.o_payload = r_node[0].valid ? r_node[0].payload : '0;

`ifdef REGISTER_TREE_PQ_ERR_EN
  logic r_err;
  logic w_ignored;

  assign w_ignored = (pq.i_push && w_full && !w_replace) || (pq.i_pop && !w_valid);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_err <= 1'b0;
    end else if (w_ignored) begin
      r_err <= 1'b1;
    end
  end

  assign pq.o_err = r_err;
`endif
endmodule
`default_nettype wire

// File: tb/tb_register_tree_pq.sv
`default_nettype none
// Testbench for register_tree_pq: max-first and min-first instances driven in lockstep,
// checked by a table, directed sequences and a queue-based reference model.
module tb_register_tree_pq;
  localparam int QS     = 4;
  localparam int KW     = 8;
  localparam int PW     = 8;
  localparam int SETTLE = 4;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  register_tree_pq_if #(.QUEUE_SIZE(QS), .KEY_WIDTH(KW), .PAYLOAD_WIDTH(PW)) ifm ();
  register_tree_pq_if #(.QUEUE_SIZE(QS), .KEY_WIDTH(KW), .PAYLOAD_WIDTH(PW)) ifn ();

  register_tree_pq #(.QUEUE_SIZE(QS), .KEY_WIDTH(KW), .PAYLOAD_WIDTH(PW), .MAX_FIRST(1)) u_max (
    .CLK(CLK), .RSTn(RSTn), .pq(ifm)
  );
  register_tree_pq #(.QUEUE_SIZE(QS), .KEY_WIDTH(KW), .PAYLOAD_WIDTH(PW), .MAX_FIRST(0)) u_min (
    .CLK(CLK), .RSTn(RSTn), .pq(ifn)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int qm[$];
  int qn[$];
  int quiet;

  typedef struct {
    bit         push;
    bit         pop;
    logic [7:0] key;
    int         size;
    bit         valid;
    int         kmax;
    int         kmin;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pl_of(input int k);
    return 8'(k) ^ 8'h5A;
  endfunction

  function automatic int best_idx(input int q[$], input bit mx);
    int b = 0;
    for (int i = 1; i < q.size(); i++) begin
      if (mx ? (q[i] > q[b]) : (q[i] < q[b])) b = i;
    end
    return b;
  endfunction

  task automatic drive(input bit p, input bit q, input logic [7:0] k, input logic [7:0] pl);
    ifm.i_push = p; ifm.i_pop = q; ifm.i_key = k; ifm.i_payload = pl;
    ifn.i_push = p; ifn.i_pop = q; ifn.i_key = k; ifn.i_payload = pl;
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    drive(0, 0, 8'd0, 8'd0);
    RSTn = 1'b0;
    step();
    step();
    RSTn = 1'b1;
    qm.delete();
    qn.delete();
    quiet = SETTLE;
  endtask

  task automatic push_key(input int k);
    drive(1, 0, 8'(k), pl_of(k));
    step();
    drive(0, 0, 8'd0, 8'd0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!(ifm.o_valid === 1'b1 && ifn.o_valid === 1'b1) && n < 20) begin
      step();
      n++;
    end
    chk(name, {31'd0, ifm.o_valid & ifn.o_valid}, 32'd1);
  endtask

  // Reference model: a multiset of keys per instance; head is valid once SETTLE
  // quiet cycles have passed since the last accepted operation.
  task automatic model_apply(input bit p, input bit q, input int k);
    bit v;
    bit acc;
    v   = (qm.size() > 0) && (quiet >= SETTLE);
    acc = 1'b0;
    if (p && q && v) begin
      qm.delete(best_idx(qm, 1)); qm.push_back(k);
      qn.delete(best_idx(qn, 0)); qn.push_back(k);
      acc = 1'b1;
    end else if (p && qm.size() < QS) begin
      qm.push_back(k); qn.push_back(k);
      acc = 1'b1;
    end else if (q && v) begin
      qm.delete(best_idx(qm, 1));
      qn.delete(best_idx(qn, 0));
      acc = 1'b1;
    end
    if (acc) quiet = 0;
    else if (quiet < SETTLE) quiet++;
  endtask

  task automatic chk_model();
    int sz;
    bit v;
    sz = qm.size();
    v  = (sz > 0) && (quiet >= SETTLE);
    chk("rnd_size_max", 32'(ifm.o_size), 32'(sz));
    chk("rnd_size_min", 32'(ifn.o_size), 32'(sz));
    chk("rnd_full", {30'd0, ifm.o_full, ifn.o_full}, {30'd0, sz == QS, sz == QS});
    chk("rnd_empty", {30'd0, ifm.o_empty, ifn.o_empty}, {30'd0, sz == 0, sz == 0});
    chk("rnd_valid", {30'd0, ifm.o_valid, ifn.o_valid}, {30'd0, v, v});
    if (v) begin
      chk("rnd_head_max", {ifm.o_payload, ifm.o_key}, {pl_of(qm[best_idx(qm, 1)]), 8'(qm[best_idx(qm, 1)])});
      chk("rnd_head_min", {ifn.o_payload, ifn.o_key}, {pl_of(qn[best_idx(qn, 0)]), 8'(qn[best_idx(qn, 0)])});
    end
  endtask

  task automatic add(input bit p, input bit q, input int k, input int sz, input bit v,
                     input int kmax, input int kmin);
    vec_t r;
    r.push = p; r.pop = q; r.key = 8'(k); r.size = sz; r.valid = v; r.kmax = kmax; r.kmin = kmin;
    vt.push_back(r);
  endtask

  task automatic add_settle(input int sz, input int kmax, input int kmin);
    for (int i = 0; i < SETTLE - 1; i++) add(0, 0, 0, sz, 0, 0, 0);
    add(0, 0, 0, sz, 1, kmax, kmin);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int em[4];
    int en[4];
    int mask_m;
    int mask_n;
    drive(0, 0, 8'd0, 8'd0);
    quiet = SETTLE;

    // Reset state and idle
    do_reset();
    for (int i = 0; i < 10; i++) step();
    chk("reset_size", {24'd0, 5'(ifm.o_size), 3'(ifn.o_size)}, 32'd0);
    chk("reset_flags", {28'd0, ifm.o_empty, ifm.o_full, ifm.o_valid, ifn.o_empty}, 32'b1001);
    chk("reset_head", {ifm.o_key, ifm.o_payload, ifn.o_key, ifn.o_payload}, 32'd0);
`ifdef REGISTER_TREE_PQ_ERR_EN
    chk("reset_err", {31'd0, ifm.o_err}, 32'd0);
`endif

    // Table: push 3,9,0,5 then drain, both orderings
    add(1, 0, 3, 1, 0, 0, 0);
    add(1, 0, 9, 2, 0, 0, 0);
    add(1, 0, 0, 3, 0, 0, 0);
    add(1, 0, 5, 4, 0, 0, 0);
    add_settle(4, 9, 0);
    add(0, 1, 0, 3, 0, 0, 0);
    add_settle(3, 5, 3);
    add(0, 1, 0, 2, 0, 0, 0);
    add_settle(2, 3, 5);
    add(0, 1, 0, 1, 0, 0, 0);
    add_settle(1, 0, 9);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].push, vt[i].pop, vt[i].key, pl_of(vt[i].key));
      step();
      chk("tbl_size", {16'd0, 8'(ifm.o_size), 8'(ifn.o_size)}, {16'd0, 8'(vt[i].size), 8'(vt[i].size)});
      chk("tbl_full_empty", {28'd0, ifm.o_full, ifm.o_empty, ifn.o_full, ifn.o_empty},
          {28'd0, vt[i].size == QS, vt[i].size == 0, vt[i].size == QS, vt[i].size == 0});
      chk("tbl_valid", {30'd0, ifm.o_valid, ifn.o_valid}, {30'd0, vt[i].valid, vt[i].valid});
      if (vt[i].valid) begin
        chk("tbl_head", {ifm.o_payload, ifm.o_key, ifn.o_payload, ifn.o_key},
            {pl_of(vt[i].kmax), 8'(vt[i].kmax), pl_of(vt[i].kmin), 8'(vt[i].kmin)});
      end
    end
    drive(0, 0, 8'd0, 8'd0);

    // Replace on a full queue
    do_reset();
    push_key(9); push_key(5); push_key(3); push_key(0);
    wait_valid("repl_settle");
    drive(1, 1, 8'd7, pl_of(7));
    chk("repl_old_head", {16'd0, ifm.o_key, ifn.o_key}, {16'd0, 8'd9, 8'd0});
    step();
    drive(0, 0, 8'd0, 8'd0);
    chk("repl_size", {16'd0, 8'(ifm.o_size), 8'(ifn.o_size)}, {16'd0, 8'd4, 8'd4});
    em = '{7, 5, 3, 0};
    en = '{3, 5, 7, 9};
    for (int i = 0; i < 4; i++) begin
      wait_valid("repl_pop_settle");
      chk("repl_pop_head", {16'd0, ifm.o_key, ifn.o_key}, {16'd0, 8'(em[i]), 8'(en[i])});
      drive(0, 1, 8'd0, 8'd0);
      step();
      drive(0, 0, 8'd0, 8'd0);
    end
    chk("repl_drained", {30'd0, ifm.o_empty, ifn.o_empty}, 32'd3);

    // Push while full is ignored and does not reload the settle counter
    do_reset();
    push_key(9); push_key(5); push_key(3); push_key(0);
    wait_valid("full_settle");
`ifdef REGISTER_TREE_PQ_ERR_EN
    chk("full_err_before", {31'd0, ifm.o_err}, 32'd0);
`endif
    drive(1, 0, 8'd1, pl_of(1));
    step();
    drive(0, 0, 8'd0, 8'd0);
    chk("full_ign_size", {16'd0, 8'(ifm.o_size), 8'(ifn.o_size)}, {16'd0, 8'd4, 8'd4});
    chk("full_ign_valid", {30'd0, ifm.o_valid, ifn.o_valid}, 32'd3);
    chk("full_ign_head", {16'd0, ifm.o_key, ifn.o_key}, {16'd0, 8'd9, 8'd0});
`ifdef REGISTER_TREE_PQ_ERR_EN
    chk("full_err_after", {31'd0, ifm.o_err}, 32'd1);
`endif

    // Pop while not valid is ignored; then equal keys
    do_reset();
    push_key(4);
    drive(0, 1, 8'd0, 8'd0);
    step();
    drive(0, 0, 8'd0, 8'd0);
    chk("pop_ign_size", {16'd0, 8'(ifm.o_size), 8'(ifn.o_size)}, {16'd0, 8'd1, 8'd1});
    step(); step();
    chk("pop_ign_still_settling", {30'd0, ifm.o_valid, ifn.o_valid}, 32'd0);
    step();
    chk("pop_ign_no_reload", {30'd0, ifm.o_valid, ifn.o_valid}, 32'd3);
`ifdef REGISTER_TREE_PQ_ERR_EN
    chk("pop_ign_err", {31'd0, ifn.o_err}, 32'd1);
`endif
    do_reset();
    drive(1, 0, 8'd4, 8'hA1); step();
    drive(1, 0, 8'd4, 8'hB2); step();
    drive(1, 0, 8'd4, 8'hC3); step();
    drive(0, 0, 8'd0, 8'd0);
    mask_m = 0;
    mask_n = 0;
    for (int i = 0; i < 3; i++) begin
      wait_valid("eq_settle");
      chk("eq_key", {16'd0, ifm.o_key, ifn.o_key}, {16'd0, 8'd4, 8'd4});
      mask_m |= (ifm.o_payload == 8'hA1) ? 1 : (ifm.o_payload == 8'hB2) ? 2 : (ifm.o_payload == 8'hC3) ? 4 : 8;
      mask_n |= (ifn.o_payload == 8'hA1) ? 1 : (ifn.o_payload == 8'hB2) ? 2 : (ifn.o_payload == 8'hC3) ? 4 : 8;
      drive(0, 1, 8'd0, 8'd0);
      step();
      drive(0, 0, 8'd0, 8'd0);
    end
    chk("eq_payload_set", {16'd0, 8'(mask_m), 8'(mask_n)}, {16'd0, 8'd7, 8'd7});
    chk("eq_empty", {30'd0, ifm.o_empty, ifn.o_empty}, 32'd3);

    // Asynchronous reset mid-sort
    push_key(3); push_key(9);
    step();
    RSTn = 1'b0;
    #1;
    chk("arst_size", {16'd0, 8'(ifm.o_size), 8'(ifn.o_size)}, 32'd0);
    chk("arst_flags", {26'd0, ifm.o_empty, ifm.o_full, ifm.o_valid, ifn.o_empty, ifn.o_full, ifn.o_valid},
        {26'd0, 6'b100100});
    chk("arst_head", {ifm.o_key, ifm.o_payload, ifn.o_key, ifn.o_payload}, 32'd0);

    // Randomised traffic against the reference model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      int r;
      int k;
      bit p;
      bit q;
      chk_model();
      r = int'($urandom_range(0, 9));
      k = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 15));
      p = (r <= 1) || (r == 4);
      q = (r == 2) || (r == 3) || (r == 4);
      drive(p, q, 8'(k), pl_of(k));
      model_apply(p, q, k);
      step();
    end
    drive(0, 0, 8'd0, 8'd0);
    chk_model();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/register_tree_pq.md
Name: register_tree_pq

Overview:
- Parametrised register-tree priority queue, the successor to the single-word register tree.
- Stores {key, payload} entries in a complete binary tree of registers and sorts them with parallel parent/child compare-swap cells.
- Selectable max-first or min-first ordering; each node carries an explicit valid bit, so key value 0 is a legal key.
- Adds a settle tracker that tells the consumer when the head entry is guaranteed correct. Sits between schedulers and arbiters in the hwpq family.

Parameters:
- QUEUE_SIZE, 128, entry capacity; power of two, >= 2. TreeDepth = log2(QUEUE_SIZE), Nodes = 2*QUEUE_SIZE-1.
- KEY_WIDTH, 16, priority key width, unsigned compare.
- PAYLOAD_WIDTH, 8, data carried with each key, never compared.
- MAX_FIRST, 1, 1 = largest key at head, 0 = smallest key at head.

Ports:
- CLK  in  1  clock
- RSTn  in  1  reset, asynchronous, active-low
- i_push  in  1  insert request
- i_pop  in  1  remove-head request
- i_key  in  KEY_WIDTH  key to insert
- i_payload  in  PAYLOAD_WIDTH  payload to insert
- o_full  out  1  size == QUEUE_SIZE
- o_empty  out  1  size == 0
- o_valid  out  1  head is settled and correct
- o_key  out  KEY_WIDTH  head key; 0 when the root is invalid
- o_payload  out  PAYLOAD_WIDTH  head payload; 0 when the root is invalid
- o_size  out  log2(QUEUE_SIZE)+1  current entry count

Behaviour:
- Reset (async): all node valid bits 0, node data 0, size 0, phase EVEN, settle counter 0. Resulting outputs: o_empty=1, o_full=0, o_valid=0, o_key=0, o_payload=0, o_size=0.
- Acceptance rules:
  - push_ok = i_push && !full.
  - pop_ok = i_pop && o_valid.
  - replace = i_push && i_pop && o_valid. A replace is permitted even when full.
- Each cycle the block is in exactly one of four modes, priority in this order: REPLACE, PUSH, POP, SORT.
- REPLACE:
  - Root <= {1, i_key, i_payload}; size unchanged.
  - The old head is the value on o_key/o_payload in that cycle.
- PUSH:
  - Entry written into the lowest-index invalid leaf, indices QUEUE_SIZE-1 .. Nodes-1; size+1.
  - A free leaf always exists when !full. Any simultaneous i_pop that is not accepted is ignored.
- POP: root valid <= 0; size-1.
- SORT (no accepted op):
  - Active cells: EVEN phase = cells on levels 0,2,4..; ODD phase = levels 1,3,5..; leaves have no cell.
  - Each active cell places the best of {parent, left, right} in the parent and writes the displaced parent into the winning child's slot.
  - "Best" follows MAX_FIRST. An invalid entry always loses. Ties: parent beats left, left beats right.
  - Phase toggles after every SORT cycle only.
- Settle counter:
  - Loads 2*TreeDepth on any accepted op.
  - Decrements by 1 per SORT cycle, saturating at 0.
  - o_valid = !o_empty && counter==0.
- Ignored requests: push while full (no replace), or pop while !o_valid, change no state and do not reload the counter.
- Outputs o_full, o_empty and o_size are combinational from registered size.
- Reset asserted mid-operation clears everything immediately; no partial state survives.

Optional Feature:
- REGISTER_TREE_PQ_ERR_EN defined: adds output o_err (1 bit, reset 0), sticky high after any ignored push (full, no replace) or ignored pop (!o_valid). Cleared only by RSTn.
- Not defined: port absent; ignored requests are silent.

Test Plan (QUEUE_SIZE=4, KEY_WIDTH=8, settle = 4 SORT cycles unless noted):
- Reset, then idle 10 cycles -> o_empty=1, o_valid=0, o_key=0, o_size=0.
- MAX_FIRST=1: push keys 3,9,0,5 on consecutive cycles, then idle 4 -> o_full=1, o_valid=1, o_key=9. Pop 4 times, each after o_valid rises -> heads 9,5,3,0 in order, then o_empty=1. Confirms key 0 is a legal key.
- MAX_FIRST=0: same pushes -> pop order 0,3,5,9.
- Full queue {9,5,3,0}: assert push key 7 together with pop once settled -> o_key=9 in that cycle, o_size stays 4; after settle, pops return 7,5,3,0.
- Full: push key 1 with no pop -> ignored, o_size=4. Pop while o_valid=0 (immediately after a push) -> ignored. With REGISTER_TREE_PQ_ERR_EN, o_err=1 after either case.
- Equal keys 4/payload 0xA1, then 4/0xB2, then 4/0xC3 -> all three pop with key 4. Assert RSTn low mid-sort -> outputs return to reset values the same cycle.
